// File: rtl/pipe_exe_md_pkg.sv
// pipe_pkg: encodings shared by the execute stage, its multiply/divide unit,
// the EX-stage bus interface and the testbench.
//   WIDTH   - datapath width
//   aluc_e  - ALU operation select carried on ealuc
//   md_op_e - multiply/divide / HI-LO access select carried on emd_op
package pipe_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        ALUC_ADD = 4'd0,
        ALUC_SUB = 4'd1,
        ALUC_AND = 4'd2,
        ALUC_OR  = 4'd3,
        ALUC_XOR = 4'd4,
        ALUC_LUI = 4'd5,
        ALUC_SLL = 4'd6,
        ALUC_SRL = 4'd7,
        ALUC_SRA = 4'd8,
        ALUC_SLT = 4'd9
    } aluc_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6,
        MD_MTHL  = 3'd7   // eimm[0] picks the target: 0 HI, 1 LO
    } md_op_e;

    // True for the four ops that launch an iterative multiply/divide.
    function automatic logic md_is_start(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/pipe_exe_md_if.sv
// pipe_exe_md_if: ID/EX -> EX -> EX/MEM signal bundle of the execute stage.
//   master: the ID/EX side (drives operands/controls, observes results)
//   slave : the execute stage itself
//   inputs : ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, emd_op,
//            ewreg_i, ewmem_i
//   outputs: ealu, eb_o, ewreg, ewmem, stall_md, md_busy
interface pipe_exe_md_if;
    import pipe_pkg::*;

    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] eimm;
    logic [WIDTH-1:0] epc4;
    logic [3:0]       ealuc;
    logic             ealuimm;
    logic             eshift;
    logic             ejal;
    logic [2:0]       emd_op;
    logic             ewreg_i;
    logic             ewmem_i;

    logic [WIDTH-1:0] ealu;
    logic [WIDTH-1:0] eb_o;
    logic             ewreg;
    logic             ewmem;
    logic             stall_md;
    logic             md_busy;

    modport master (
        output ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, emd_op,
               ewreg_i, ewmem_i,
        input  ealu, eb_o, ewreg, ewmem, stall_md, md_busy
    );

    modport slave (
        input  ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, emd_op,
               ewreg_i, ewmem_i,
        output ealu, eb_o, ewreg, ewmem, stall_md, md_busy
    );

endinterface

// File: rtl/pipe_exe_md_md_unit.sv
// pipe_md_unit: HI/LO registers plus an iterative multiply/divide engine
// that retires one bit per cycle (shift-add multiply, restoring divide).
//   clock, reset : pipeline clock, asynchronous active-high reset
//   op           : emd_op from the execute stage
//   a, b         : operands (a is also the mthi/mtlo source)
//   sel_lo       : mthi/mtlo target select (0 HI, 1 LO)
//   busy         : an operation is in flight
//   hi, lo       : architectural HI/LO
// Ops are only accepted while idle; whenever busy the execute stage stalls
// any md op, so "idle" and "not stalled" coincide here.
module pipe_md_unit
    import pipe_pkg::*;
#(
    parameter int W         = WIDTH,
    parameter int MD_CYCLES = WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel_lo,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          is_div;
    logic          neg_lo;    // negate product (mult) or quotient (div)
    logic          neg_hi;    // negate remainder (signed div)
    // mult: acc_hi = partial product, acc_lo = multiplier shifting out / product low
    // div : acc_hi = partial remainder, acc_lo = dividend shifting out / quotient in
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  opnd;      // multiplicand or divisor magnitude

    logic          start;
    logic          mthl;
    logic          op_div;
    logic          op_signed;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;

    assign start  = (state == S_IDLE) && md_is_start(op);
    assign mthl   = (state == S_IDLE) && (op == MD_MTHL);
    assign op_div = (op == MD_DIV) || (op == MD_DIVU);
    // A signed divide by zero runs unsigned so the raw dividend lands in HI
    // and LO comes out all ones, exactly like divu.
    assign op_signed = (op == MD_MULT) || ((op == MD_DIV) && (b != '0));
    assign a_mag     = (op_signed && a[W-1]) ? -a : a;
    assign b_mag     = (op_signed && b[W-1]) ? -b : b;

    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_sub;
    logic [W-1:0]   step_hi;
    logic [W-1:0]   step_lo;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   fin_hi;
    logic [W-1:0]   fin_lo;

    always_comb begin
        // NOTE: every variable gets a value before any branch so this block
        // stays purely combinational (no latch on an untaken path).
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[W-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_sub   = div_shift[W-1:0] - opnd;   // exact whenever div_ge holds
        step_hi   = mul_sum[W:1];
        step_lo   = {mul_sum[0], acc_lo[W-1:1]};
        if (is_div) begin
            step_hi = div_ge ? div_sub : div_shift[W-1:0];
            step_lo = {acc_lo[W-2:0], div_ge};
        end

        // Sign correction applied to the value produced by the final step.
        prod_fix = neg_lo ? -{step_hi, step_lo} : {step_hi, step_lo};
        fin_hi   = prod_fix[2*W-1:W];
        fin_lo   = prod_fix[W-1:0];
        if (is_div) begin
            fin_hi = neg_hi ? -step_hi : step_hi;
            fin_lo = neg_lo ? -step_lo : step_lo;
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        cnt    <= CW'(MD_CYCLES);
                        is_div <= op_div;
                        neg_lo <= op_signed && (a[W-1] ^ b[W-1]);
                        neg_hi <= op_signed && op_div && a[W-1];
                        acc_hi <= '0;
                        acc_lo <= op_div ? a_mag : b_mag;
                        opnd   <= op_div ? b_mag : a_mag;
                    end else if (mthl) begin
                        if (sel_lo) lo <= a;
                        else        hi <= a;
                    end
                end
                default: begin   // S_RUN
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);

endmodule

// File: rtl/pipe_exe_md.sv
// pipe_exe_md: execute stage of the five-stage pipeline, between ID/EX and
// EX/MEM. Computes the ALU/jal/HI/LO result, passes store data through, and
// gates the write enables while the multiply/divide unit forces a stall.
//   clock, reset : pipeline clock, asynchronous active-high reset
//   bus (slave)  : ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, emd_op,
//                  ewreg_i, ewmem_i in; ealu, eb_o, ewreg, ewmem, stall_md,
//                  md_busy out
// Parameters: WIDTH datapath width, MD_CYCLES iterations per mul/div (must
// equal WIDTH since one operand bit is retired per cycle).
module pipe_exe_md #(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic          clock,
    input  logic          reset,
    pipe_exe_md_if.slave  bus
);
    import pipe_pkg::*;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] b_op;
    logic [4:0]       sa;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] result;

    pipe_md_unit #(
        .W         (WIDTH),
        .MD_CYCLES (MD_CYCLES)
    ) u_md (
        .clock  (clock),
        .reset  (reset),
        .op     (bus.emd_op),
        .a      (bus.ea),
        .b      (bus.eb),
        .sel_lo (bus.eimm[0]),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    // Any HI/LO access or new mul/div waits for the one in flight; plain ALU
    // instructions keep flowing underneath it.
    assign stall = busy && (bus.emd_op != MD_NONE);

    assign b_op = bus.ealuimm ? bus.eimm : bus.eb;
    assign sa   = bus.eshift ? bus.ea[4:0] : bus.eimm[10:6];

    always_comb begin
        alu_out = '0;
        case (bus.ealuc)
            ALUC_ADD: alu_out = bus.ea + b_op;
            ALUC_SUB: alu_out = bus.ea - b_op;
            ALUC_AND: alu_out = bus.ea & b_op;
            ALUC_OR:  alu_out = bus.ea | b_op;
            ALUC_XOR: alu_out = bus.ea ^ b_op;
            ALUC_LUI: alu_out = {b_op[15:0], 16'h0};
            ALUC_SLL: alu_out = b_op << sa;
            ALUC_SRL: alu_out = b_op >> sa;
            ALUC_SRA: alu_out = $signed(b_op) >>> sa;
            ALUC_SLT: alu_out = {{(WIDTH-1){1'b0}}, $signed(bus.ea) < $signed(b_op)};
            default:  alu_out = '0;
        endcase
    end

    always_comb begin
        if (bus.ejal)                    result = bus.epc4 + WIDTH'(4);
        else if (bus.emd_op == MD_MFHI)  result = hi;
        else if (bus.emd_op == MD_MFLO)  result = lo;
        else                             result = alu_out;
    end

    assign bus.ealu     = result;
    assign bus.eb_o     = bus.eb;
    assign bus.ewreg    = bus.ewreg_i & ~stall;
    assign bus.ewmem    = bus.ewmem_i & ~stall;
    assign bus.stall_md = stall;
    assign bus.md_busy  = busy;

endmodule

// File: tb/tb_pipe_exe_md.sv
// Self-checking bench for pipe_exe_md: a cycle-level model (plain arithmetic
// for products/quotients plus a busy countdown) is compared against the DUT
// at every falling edge, and directed vectors pin literal expectations.
module tb_pipe_exe_md;
    import pipe_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    bit   cmp_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    pipe_exe_md_if bus ();

    pipe_exe_md #(.WIDTH(32), .MD_CYCLES(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [63:0] m_pend = 64'h0;   // {HI, LO} that the running op will deliver
    int          m_left = 0;       // cycles of busy remaining

    function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'h0;
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: res = {32'h0, a} * {32'h0, b};
            3'd3: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
            default: res = 64'h0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] s);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return b << 16;
            4'd6: return b << s;
            4'd7: return b >> s;
            4'd8: return $signed(b) >>> s;
            4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_hi   <= 32'h0;
            m_lo   <= 32'h0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (bus.emd_op inside {[3'd1:3'd4]}) begin
            m_pend <= md_result(bus.emd_op, bus.ea, bus.eb);
            m_left <= 32;
        end else if (bus.emd_op == 3'd7) begin
            if (bus.eimm[0]) m_lo <= bus.ea;
            else             m_hi <= bus.ea;
        end
    end

    logic        e_busy;
    logic        e_stall;
    logic [31:0] e_res;

    always @(negedge clock) begin
        if (cmp_en) begin
            e_busy  = (m_left > 0);
            e_stall = e_busy && (bus.emd_op != 3'd0);
            if (bus.ejal)              e_res = bus.epc4 + 32'd4;
            else if (bus.emd_op == 3'd5) e_res = m_hi;
            else if (bus.emd_op == 3'd6) e_res = m_lo;
            else e_res = alu_model(bus.ealuc, bus.ea,
                                   bus.ealuimm ? bus.eimm : bus.eb,
                                   bus.eshift ? bus.ea[4:0] : bus.eimm[10:6]);
            check("model_ealu",  bus.ealu, e_res);
            check("model_eb_o",  bus.eb_o, bus.eb);
            check("model_stall", 32'(bus.stall_md), 32'(e_stall));
            check("model_busy",  32'(bus.md_busy), 32'(e_busy));
            check("model_ewreg", 32'(bus.ewreg), 32'(bus.ewreg_i & ~e_stall));
            check("model_ewmem", 32'(bus.ewmem), 32'(bus.ewmem_i & ~e_stall));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] c, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        @(posedge clock);
        #1;
        bus.ealuc   = c;
        bus.emd_op  = op;
        bus.ea      = a;
        bus.eb      = b;
        bus.eimm    = imm;
        bus.epc4    = 32'h0000_1000;
        bus.ealuimm = 1'b0;
        bus.eshift  = 1'b0;
        bus.ejal    = 1'b0;
        bus.ewreg_i = 1'b1;
        bus.ewmem_i = 1'b0;
    endtask

    task automatic nops(input int n);
        repeat (n) drive(ALUC_ADD, MD_NONE, 32'h0, 32'h0, 32'h0);
    endtask

    // Holds the current inputs until stall_md drops; n = stalled cycles seen.
    task automatic wait_unstall(output int n);
        n = 0;
        @(negedge clock);
        while (bus.stall_md === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    // Issue a single md read and check the value it returns.
    task automatic read_md(input logic [2:0] op, input string name, input logic [31:0] exp);
        drive(ALUC_ADD, op, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        check({name, "_stall"}, 32'(bus.stall_md), 32'h0);
        check(name, bus.ealu, exp);
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(ALUC_ADD, op, a, b, 32'h0);
        nops(32);
        read_md(MD_MFLO, {name, "_lo"}, exp_lo);
        read_md(MD_MFHI, {name, "_hi"}, exp_hi);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.ealuc = 4'd0; bus.emd_op = 3'd0; bus.ea = 32'h0; bus.eb = 32'h0;
        bus.eimm = 32'h0; bus.epc4 = 32'h0; bus.ealuimm = 1'b0; bus.eshift = 1'b0;
        bus.ejal = 1'b0; bus.ewreg_i = 1'b0; bus.ewmem_i = 1'b0;

        // Reset state.
        #1 reset = 1'b1;
        @(negedge clock);
        cmp_en = 1'b1;
        check("rst_ealu",  bus.ealu, 32'h0);
        check("rst_stall", 32'(bus.stall_md), 32'h0);
        check("rst_ewreg", 32'(bus.ewreg), 32'h0);
        check("rst_ewmem", 32'(bus.ewmem), 32'h0);
        check("rst_busy",  32'(bus.md_busy), 32'h0);
        @(posedge clock);
        #2 reset = 1'b0;

        // Wrapping add, store passthrough.
        drive(ALUC_ADD, MD_NONE, 32'h7FFF_FFFF, 32'h1, 32'h0);
        bus.ewmem_i = 1'b1;
        @(negedge clock);
        check("add_wrap",  bus.ealu, 32'h8000_0000);
        check("add_ewmem", 32'(bus.ewmem), 32'h1);
        check("add_eb_o",  bus.eb_o, 32'h1);
        check("add_stall", 32'(bus.stall_md), 32'h0);

        // Signed mult, mflo issued right behind it.
        drive(ALUC_ADD, MD_MULT, 32'hFFFF_FFFE, 32'h3, 32'h0);
        @(negedge clock);
        check("mult_issue_stall", 32'(bus.stall_md), 32'h0);
        drive(ALUC_ADD, MD_MFLO, 32'h0, 32'h0, 32'h0);
        wait_unstall(n);
        check("mult_stall_cycles", 32'(n), 32'd32);
        check("mult_lo", bus.ealu, 32'hFFFF_FFFA);
        check("mult_lo_ewreg", 32'(bus.ewreg), 32'h1);
        read_md(MD_MFHI, "mult_hi", 32'hFFFF_FFFF);

        // multu, mfhi in cycle T+33 must not stall.
        drive(ALUC_ADD, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        drive(ALUC_ADD, MD_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        check("multu_busy_t1", 32'(bus.md_busy), 32'h1);
        nops(30);
        drive(ALUC_ADD, MD_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        check("multu_busy_t32", 32'(bus.md_busy), 32'h1);
        read_md(MD_MFHI, "multu_hi", 32'hFFFF_FFFE);
        read_md(MD_MFLO, "multu_lo", 32'h0000_0001);

        // Divides, including divide by zero and the overflow corner.
        run_md(MD_DIV,  32'hFFFF_FFF9, 32'h2,          "div_m7_2",  32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md(MD_DIVU, 32'd100,       32'h0,          "divu_by0",  32'd100,       32'hFFFF_FFFF);
        run_md(MD_DIV,  32'hFFFF_FFFB, 32'h0,          "div_by0",   32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_md(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  "div_min",   32'h0,         32'h8000_0000);
        run_md(MD_DIVU, 32'd1000,      32'd7,          "divu_1000", 32'd6,         32'd142);

        // Overlap: ALU work under a multu, then a conflicting multu at T+5.
        drive(ALUC_ADD, MD_MULTU, 32'd5, 32'd6, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            drive(ALUC_ADD, MD_NONE, i * 1000, i, 32'h0);
            @(negedge clock);
            check("ovl_add", bus.ealu, i * 1001);
            check("ovl_add_ewreg", 32'(bus.ewreg), 32'h1);
        end
        drive(ALUC_ADD, MD_MULTU, 32'd7, 32'd8, 32'h0);
        bus.ewmem_i = 1'b1;
        @(negedge clock);
        check("ovl_conflict_stall", 32'(bus.stall_md), 32'h1);
        check("ovl_conflict_ewmem", 32'(bus.ewmem), 32'h0);
        check("ovl_conflict_ewreg", 32'(bus.ewreg), 32'h0);
        wait_unstall(n);
        check("ovl_conflict_cycles", 32'(n), 32'd27);
        for (int i = 0; i < 6; i++) begin
            drive(ALUC_ADD, MD_NONE, 32'h10 + i, 32'h20, 32'h0);
            @(negedge clock);
            check("ovl_add2", bus.ealu, 32'h30 + i);
            check("ovl_add2_busy", 32'(bus.md_busy), 32'h1);
        end
        nops(26);
        read_md(MD_MFLO, "ovl_lo", 32'd56);
        read_md(MD_MFHI, "ovl_hi", 32'd0);

        // mthi/mtlo, then reset in the middle of a divide.
        drive(ALUC_ADD, MD_MTHL, 32'h55, 32'h0, 32'h0);
        drive(ALUC_ADD, MD_MTHL, 32'h66, 32'h0, 32'h1);
        read_md(MD_MFHI, "mthi_55", 32'h55);
        read_md(MD_MFLO, "mtlo_66", 32'h66);
        drive(ALUC_ADD, MD_DIV, 32'd1000, 32'd7, 32'h0);
        nops(9);
        drive(ALUC_ADD, MD_MFHI, 32'h0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.md_busy), 32'h0);
        check("rst_mid_hi",   bus.ealu, 32'h0);
        bus.emd_op = MD_MFLO;
        #1;
        check("rst_mid_lo",   bus.ealu, 32'h0);
        @(posedge clock);
        #2 reset = 1'b0;
        read_md(MD_MFHI, "post_rst_hi", 32'h0);
        read_md(MD_MFLO, "post_rst_lo", 32'h0);
        drive(ALUC_ADD, MD_MTHL, 32'h1234, 32'h0, 32'h0);
        read_md(MD_MFHI, "mthi_1234", 32'h1234);

        // ALU operations and result priority.
        drive(ALUC_SUB, MD_NONE, 32'd5, 32'd7, 32'h0);
        @(negedge clock); check("sub", bus.ealu, 32'hFFFF_FFFE);
        drive(ALUC_AND, MD_NONE, 32'hF0F0, 32'hFF00, 32'h0);
        @(negedge clock); check("and", bus.ealu, 32'hF000);
        drive(ALUC_OR, MD_NONE, 32'hF0F0, 32'hFF00, 32'h0);
        @(negedge clock); check("or", bus.ealu, 32'hFFF0);
        drive(ALUC_XOR, MD_NONE, 32'hF0F0, 32'hFF00, 32'h0);
        @(negedge clock); check("xor", bus.ealu, 32'h0FF0);
        drive(ALUC_LUI, MD_NONE, 32'h0, 32'h0, 32'h0000_ABCD);
        bus.ealuimm = 1'b1;
        @(negedge clock); check("lui", bus.ealu, 32'hABCD_0000);
        drive(ALUC_SLL, MD_NONE, 32'h0, 32'h1, 32'h0000_0100);
        @(negedge clock); check("sll_imm", bus.ealu, 32'h10);
        drive(ALUC_SRL, MD_NONE, 32'd8, 32'h8000_0000, 32'h0);
        bus.eshift = 1'b1;
        @(negedge clock); check("srl_reg", bus.ealu, 32'h0080_0000);
        drive(ALUC_SRA, MD_NONE, 32'd4, 32'h8000_0000, 32'h0);
        bus.eshift = 1'b1;
        @(negedge clock); check("sra_reg", bus.ealu, 32'hF800_0000);
        drive(ALUC_SLT, MD_NONE, 32'hFFFF_FFFF, 32'h1, 32'h0);
        @(negedge clock); check("slt_true", bus.ealu, 32'h1);
        drive(ALUC_SLT, MD_NONE, 32'h1, 32'hFFFF_FFFF, 32'h0);
        @(negedge clock); check("slt_false", bus.ealu, 32'h0);
        drive(4'd12, MD_NONE, 32'h1234, 32'h5678, 32'h0);
        @(negedge clock); check("aluc_undef", bus.ealu, 32'h0);
        drive(ALUC_ADD, MD_MFHI, 32'h0, 32'h0, 32'h0);
        bus.epc4 = 32'h0000_0400;
        bus.ejal = 1'b1;
        @(negedge clock); check("jal_over_mfhi", bus.ealu, 32'h0000_0404);

        nops(1);
        @(negedge clock);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
